// File: rtl/cpu_xbus_ctrl_if.sv
// cpu_xbus_ctrl_if
//  Bundles the CPU request/response handshake and the multiplexed uio bus
//  pins of cpu_xbus_ctrl into one interface.
//  Handshake: a request transfers on a rising edge where req_valid and
//  req_ready are both high; req_we/req_addr/req_wdata must be stable while
//  req_valid is high. rsp_valid is a one-cycle pulse with no backpressure.
//  Modports:
//   slave  - controller side (drives req_ready, rsp_*, bus_out/bus_oe, strobes)
//   master - CPU / external-device side (drives req_*, bus_in, ext_ack)
interface cpu_xbus_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [7:0]        rsp_rdata;
  logic [7:0]        bus_in;
  logic [7:0]        bus_out;
  logic [7:0]        bus_oe;
  logic              ale;
  logic              rd_n;
  logic              wr_n;
  logic              ext_ack;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, bus_in, ext_ack,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output bus_out, bus_oe, ale, rd_n, wr_n
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, bus_in, ext_ack,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  bus_out, bus_oe, ale, rd_n, wr_n
  );
endinterface

// File: rtl/cpu_xbus_ctrl.sv
// cpu_xbus_ctrl
//  External-memory bus controller for the 8-bit CPU. A single load/store
//  request becomes a time-multiplexed transfer on the 8 uio pins:
//  ADDR_W/8 address bytes (MSB first, ale high), then one data byte with
//  rd_n or wr_n low until ext_ack or a timeout of WAIT_MAX+1 cycles.
//  Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   ena         - gates acceptance of new requests only
//   xb          - cpu_xbus_ctrl_if.slave: request/response handshake + bus pins
//   dbg_state   - current FSM state (encoding of state_t)
//  All bus outputs and response signals are registers; req_ready is
//  ena & rst_n & (state == IDLE).
module cpu_xbus_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  cpu_xbus_ctrl_if.slave    xb,
  output logic [2:0]        dbg_state
);

  localparam int NB    = ADDR_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_TURN  = 3'd3,
    S_RDATA = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [7:0]        wdata_q;

  logic [7:0]        bus_out_q;
  logic [7:0]        bus_oe_q;
  logic              ale_q;
  logic              rd_n_q;
  logic              wr_n_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [7:0]        rsp_rdata_q;

  logic              req_ready_w;
  logic              hs;
  logic              idx_last;
  logic              cnt_last;

  // Byte k of an address, k = 0 being the least significant byte.
  function automatic logic [7:0] addr_byte(input logic [ADDR_W-1:0] a, input int k);
    return a[8*k +: 8];
  endfunction

  // rst_n is folded in so req_ready is low while reset is held.
  assign req_ready_w = ena && rst_n && (state == S_IDLE);
  assign hs          = xb.req_valid && req_ready_w;
  assign idx_last    = (idx == IDX_W'(NB - 1));
  assign cnt_last    = (cnt == CNT_W'(WAIT_MAX));

  // Output registers are loaded with the values belonging to the state being
  // entered, so every output is a pure function of registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      cnt         <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      bus_out_q   <= '0;
      bus_oe_q    <= '0;
      ale_q       <= 1'b0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      // Idle bus values unless the next state overrides them.
      bus_out_q   <= '0;
      bus_oe_q    <= '0;
      ale_q       <= 1'b0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hs) begin
            state     <= S_ADDR;
            idx       <= '0;
            addr_q    <= xb.req_addr;
            we_q      <= xb.req_we;
            wdata_q   <= xb.req_wdata;
            bus_oe_q  <= 8'hFF;
            ale_q     <= 1'b1;
            bus_out_q <= xb.req_addr[ADDR_W-1 -: 8];
          end
        end
        S_ADDR: begin
          if (idx_last) begin
            if (we_q) begin
              state     <= S_WDATA;
              cnt       <= '0;
              bus_oe_q  <= 8'hFF;
              bus_out_q <= wdata_q;
              wr_n_q    <= 1'b0;
            end else begin
              // Turnaround cycle: everything released before the device drives.
              state <= S_TURN;
            end
          end else begin
            idx       <= idx + 1'b1;
            bus_oe_q  <= 8'hFF;
            ale_q     <= 1'b1;
            bus_out_q <= addr_byte(addr_q, NB - 2 - int'(idx));
          end
        end
        S_TURN: begin
          state  <= S_RDATA;
          cnt    <= '0;
          rd_n_q <= 1'b0;
        end
        S_WDATA: begin
          // Ack is checked first so an ack in the last wait cycle succeeds.
          if (xb.ext_ack || cnt_last) begin
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= !xb.ext_ack;
          end else begin
            cnt       <= cnt + 1'b1;
            bus_oe_q  <= 8'hFF;
            bus_out_q <= wdata_q;
            wr_n_q    <= 1'b0;
          end
        end
        S_RDATA: begin
          if (xb.ext_ack) begin
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= xb.bus_in;
          end else if (cnt_last) begin
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else begin
            cnt    <= cnt + 1'b1;
            rd_n_q <= 1'b0;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign xb.req_ready = req_ready_w;
  assign xb.rsp_valid = rsp_valid_q;
  assign xb.rsp_err   = rsp_err_q;
  assign xb.rsp_rdata = rsp_rdata_q;
  assign xb.bus_out   = bus_out_q;
  assign xb.bus_oe    = bus_oe_q;
  assign xb.ale       = ale_q;
  assign xb.rd_n      = rd_n_q;
  assign xb.wr_n      = wr_n_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_cpu_xbus_ctrl.sv
// Bench for cpu_xbus_ctrl: a 16-bit-address instance (main tests) and a
// 24-bit-address instance (back-to-back reads). The expected bus trace of a
// transfer is built as a list of phases (address bytes, data phase, response)
// and compared cycle by cycle.
module tb_cpu_xbus_ctrl;
  localparam int WAIT_MAX = 15;
  localparam int NEVER    = 99;

  typedef logic [19:0] cyc_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
    int          dly;
    logic [7:0]  bin;
    logic        junk;
    logic        exp_err;
    logic [7:0]  exp_rd;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  always #5 clk = ~clk;

  cpu_xbus_ctrl_if #(.ADDR_W(16)) xa ();
  cpu_xbus_ctrl_if #(.ADDR_W(24)) xw ();
  logic [2:0] dbg_a;
  logic [2:0] dbg_w;

  cpu_xbus_ctrl #(.ADDR_W(16), .WAIT_MAX(WAIT_MAX)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .xb(xa.slave), .dbg_state(dbg_a)
  );
  cpu_xbus_ctrl #(.ADDR_W(24), .WAIT_MAX(WAIT_MAX)) dut_w (
    .clk(clk), .rst_n(rst_n), .ena(ena), .xb(xw.slave), .dbg_state(dbg_w)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [19:0] exp_q[$];
  logic [7:0] rd_model = 8'h00;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic cyc_t mk(input logic [7:0] oe, input logic [7:0] out,
                              input logic ale, input logic rd, input logic wr, input logic rv);
    return {oe, out, ale, rd, wr, rv};
  endfunction

  // Reference: address bytes MSB first, data phase of ack delay + 1 cycles
  // (capped at WAIT_MAX+1), a turnaround cycle before read data, one RESP cycle.
  task automatic model_txn(input int nb, input logic we, input logic [23:0] addr,
                           input logic [7:0] wd, input int dly);
    int data_len;
    data_len = (dly <= WAIT_MAX) ? dly + 1 : WAIT_MAX + 1;
    for (int k = 0; k < nb; k++) exp_q.push_back(mk(8'hFF, addr[8*(nb-1-k) +: 8], 1'b1, 1'b1, 1'b1, 1'b0));
    if (we) begin
      for (int k = 0; k < data_len; k++) exp_q.push_back(mk(8'hFF, wd, 1'b0, 1'b1, 1'b0, 1'b0));
    end else begin
      exp_q.push_back(mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0));
      for (int k = 0; k < data_len; k++) exp_q.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
    end
    exp_q.push_back(mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1));
  endtask

  function automatic cyc_t act_a();
    return mk(xa.bus_oe, xa.bus_out, xa.ale, xa.rd_n, xa.wr_n, xa.rsp_valid);
  endfunction

  function automatic cyc_t act_w();
    return mk(xw.bus_oe, xw.bus_out, xw.ale, xw.rd_n, xw.wr_n, xw.rsp_valid);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready_a(input string tag, output bit ok);
    int w;
    w = 0;
    while (xa.req_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    ok = (w < 20);
    if (!ok) check({tag, " ready_timeout"}, 32'd0, 32'd1);
  endtask

  // One transfer on dut_a. dly = data-phase cycle in which ext_ack is raised
  // (NEVER = no ack); junk raises ext_ack throughout ADDR/TURN.
  task automatic do_txn_a(input string tag, input logic we, input logic [15:0] addr,
                          input logic [7:0] wd, input int dly, input logic [7:0] bin,
                          input logic junk, input logic exp_err, input logic [7:0] exp_rd);
    int len, data_start, ack_cyc;
    bit ok;
    cyc_t e;
    xa.req_we    = we;
    xa.req_addr  = addr;
    xa.req_wdata = wd;
    xa.bus_in    = bin;
    xa.ext_ack   = 1'b0;
    xa.req_valid = 1'b1;
    wait_ready_a(tag, ok);
    if (!ok) begin
      xa.req_valid = 1'b0;
      return;
    end
    exp_q.delete();
    model_txn(2, we, {8'h00, addr}, wd, dly);
    len        = exp_q.size();
    data_start = we ? 3 : 4;
    ack_cyc    = (dly <= WAIT_MAX) ? data_start + dly : -1;
    for (int c = 1; c <= len; c++) begin
      @(posedge clk); #1;
      if (c == 1) xa.req_valid = 1'b0;
      xa.ext_ack = (c == ack_cyc) || (junk && c < data_start);
      e = exp_q.pop_front();
      check($sformatf("%s trace c%0d", tag, c), 32'(act_a()), 32'(e));
      if (c == len) begin
        check({tag, " rsp_err"}, 32'(xa.rsp_err), 32'(exp_err));
        check({tag, " rsp_rdata"}, 32'(xa.rsp_rdata), 32'(exp_rd));
      end
    end
    @(posedge clk); #1;
    xa.ext_ack = 1'b0;
    check({tag, " ready_after"}, 32'(xa.req_ready), 32'd1);
    check({tag, " rsp_valid_after"}, 32'(xa.rsp_valid), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit ok;
    xa.req_valid = 1'b0; xa.req_we = 1'b0; xa.req_addr = '0; xa.req_wdata = '0;
    xa.bus_in = '0; xa.ext_ack = 1'b0;
    xw.req_valid = 1'b0; xw.req_we = 1'b0; xw.req_addr = '0; xw.req_wdata = '0;
    xw.bus_in = '0; xw.ext_ack = 1'b0;

    tbl[0] = '{1'b1, 16'h12A5, 8'h3C, 0,     8'h00, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 16'h00FF, 8'h00, 2,     8'h5A, 1'b0, 1'b0, 8'h5A};
    tbl[2] = '{1'b1, 16'h4321, 8'h77, NEVER, 8'hEE, 1'b0, 1'b1, 8'h5A};
    tbl[3] = '{1'b0, 16'hBEEF, 8'h00, 15,    8'hC3, 1'b1, 1'b0, 8'hC3};
    tbl[4] = '{1'b0, 16'h0001, 8'h00, NEVER, 8'h11, 1'b0, 1'b1, 8'hC3};
    tbl[5] = '{1'b1, 16'hFFFF, 8'hA0, 15,    8'h22, 1'b1, 1'b0, 8'hC3};

    // Reset values, with ena already high to show req_ready is held low.
    ena = 1'b1;
    #12;
    check("rst req_ready", 32'(xa.req_ready), 32'd0);
    check("rst bus", 32'(act_a()), 32'(mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0)));
    check("rst rsp_err", 32'(xa.rsp_err), 32'd0);
    check("rst rsp_rdata", 32'(xa.rsp_rdata), 32'd0);
    check("rst state", 32'(dbg_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    foreach (tbl[i]) begin
      do_txn_a($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].dly,
               tbl[i].bin, tbl[i].junk, tbl[i].exp_err, tbl[i].exp_rd);
    end

    // Reset in the middle of RDATA, then ena=0 blocks requests.
    xa.req_we = 1'b0; xa.req_addr = 16'h2468; xa.bus_in = 8'h99; xa.ext_ack = 1'b0;
    xa.req_valid = 1'b1;
    wait_ready_a("rstmid", ok);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c == 1) xa.req_valid = 1'b0;
    end
    check("rstmid in_rdata rd_n", 32'(xa.rd_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid oe", 32'(xa.bus_oe), 32'd0);
    check("rstmid rd_n", 32'(xa.rd_n), 32'd1);
    check("rstmid rsp_valid", 32'(xa.rsp_valid), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("rstmid held rsp_valid", 32'(xa.rsp_valid), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b0;
    xa.req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("ena0 req_ready", 32'(xa.req_ready), 32'd0);
      check("ena0 bus", 32'(act_a()), 32'(mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0)));
      check("ena0 state", 32'(dbg_a), 32'd0);
    end
    check("post-reset rsp_rdata", 32'(xa.rsp_rdata), 32'd0);
    xa.req_valid = 1'b0;
    ena = 1'b1;
    rd_model = 8'h00;
    @(posedge clk); #1;

    // Randomized transfers against the model.
    for (int i = 0; i < 25; i++) begin
      logic we;
      logic [15:0] addr;
      logic [7:0] wd, bin;
      int dly, sel;
      logic junk, err;
      we   = 1'($urandom_range(0, 1));
      addr = 16'($urandom);
      wd   = 8'($urandom);
      bin  = 8'($urandom);
      junk = 1'($urandom_range(0, 1));
      sel  = $urandom_range(0, 7);
      dly  = (sel == 0) ? NEVER : (sel == 1) ? WAIT_MAX : $urandom_range(0, 4);
      err  = (dly > WAIT_MAX);
      if (!we && !err) rd_model = bin;
      do_txn_a($sformatf("rnd%0d", i), we, addr, wd, dly, bin, junk, err, rd_model);
    end

    // 24-bit instance: two back-to-back reads with req_valid held.
    xw.bus_in = 8'h6E;
    xw.ext_ack = 1'b1;
    xw.req_we = 1'b0;
    xw.req_addr = 24'hABCDEF;
    xw.req_valid = 1'b1;
    begin
      int w;
      w = 0;
      while (xw.req_ready !== 1'b1 && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      check("b2b ready wait", 32'(w < 20), 32'd1);
    end
    exp_q.delete();
    model_txn(3, 1'b0, 24'hABCDEF, 8'h00, 0);
    exp_q.push_back(mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0));
    model_txn(3, 1'b0, 24'h123456, 8'h00, 0);
    for (int c = 1; c <= 13; c++) begin
      cyc_t e;
      @(posedge clk); #1;
      if (c == 1) xw.req_addr = 24'h123456;
      if (c == 8) xw.req_valid = 1'b0;
      if (c == 7) check("b2b second handshake ready", 32'(xw.req_ready), 32'd1);
      e = exp_q.pop_front();
      check($sformatf("b2b trace c%0d", c), 32'(act_w()), 32'(e));
    end
    check("b2b rsp_rdata", 32'(xw.rsp_rdata), 32'h6E);
    check("b2b rsp_err", 32'(xw.rsp_err), 32'd0);
    xw.ext_ack = 1'b0;

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
